// File: rtl/button_mmio_if.sv
// button_mmio_if: data-memory bus slice seen by the button responder
interface button_mmio_if;
    logic [31:0] address_dmem;
    logic        wren;
    logic [31:0] data;
    logic        sel;
    logic [31:0] q_btn;
    modport master (output address_dmem, wren, data, input sel, q_btn);
    modport slave (input address_dmem, wren, data, output sel, q_btn);
endinterface

// File: rtl/button_mmio.sv
// button_mmio: debounced push-button on the dmem bus; BUTTON_PRESS_COUNT_EN adds a saturating press counter in q_btn[15:8]
module button_mmio #(
    parameter logic [31:0] BUTTON_ADDR     = 32'd1000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           btn_raw,
    button_mmio_if.slave   bus,
    output logic           btn_level,
    output logic           press_pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1, s2, press, ack;
    logic [7:0]    cnt_field;
    logic          unused_data;
    always_ff @(posedge clock or negedge reset)
        if (!reset) {s1, s2} <= 2'b00;
        else {s1, s2} <= {btn_raw, s1};
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        press = 1'b0;
        case (state_q)
            LOW: if (s2) begin
                state_d = RISE;
                cnt_d = CW'(1);
            end
            RISE: if (!s2) begin
                state_d = LOW;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == FULL) begin
                    state_d = HIGH;
                    cnt_d = '0;
                    press = 1'b1;
                end
            end
            HIGH: if (!s2) begin
                state_d = FALL;
                cnt_d = CW'(1);
            end
            default: if (s2) begin
                state_d = HIGH;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == FULL) begin
                    state_d = LOW;
                    cnt_d = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q <= LOW;
            cnt_q <= '0;
            btn_level <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            btn_level <= (state_d == HIGH) || (state_d == FALL);
        end
    assign bus.sel = bus.address_dmem == BUTTON_ADDR;
    assign ack = bus.wren && bus.sel && bus.data[1];
    // a press landing on the acknowledge cycle must not be lost
    always_ff @(posedge clock or negedge reset)
        if (!reset) press_pending <= 1'b0;
        else press_pending <= press ? 1'b1 : ack ? 1'b0 : press_pending;
`ifdef BUTTON_PRESS_COUNT_EN
    logic [7:0] press_cnt;
    always_ff @(posedge clock or negedge reset)
        if (!reset) press_cnt <= 8'h00;
        else if (ack) press_cnt <= {7'b0, press};
        else if (press && press_cnt != 8'hFF) press_cnt <= press_cnt + 8'd1;
    assign cnt_field = press_cnt;
`else
    assign cnt_field = 8'h00;
`endif
    assign unused_data = ^{bus.data[31:2], bus.data[0]};
    assign bus.q_btn = bus.sel ? {16'h0, cnt_field, 6'h0, press_pending, btn_level} : 32'h0;
endmodule
